// File: rtl/flash_prog_sequencer_if.sv
// rtl/flash_prog_sequencer_if.sv - command/completion channel between the programming sequencer and the flash macro engine
//
// Signals:
//   macro_states            command code (4'hA erase sector, 4'hC write page, 4'hD read page)
//   macro_states_valid      one-cycle command strobe
//   addr_reg                byte address of the current command
//   flash_macro_states_done one-cycle completion from the flash engine
//   buff_page_ready         a full page of program data is buffered upstream
//   verify_pass/verify_fail read-back verdict pulses (only with FLASH_PROG_SEQ_VERIFY_EN)
// Modports: master = sequencer side, slave = flash engine / buffer side.
interface flash_prog_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic [3:0]        macro_states;
    logic              macro_states_valid;
    logic [ADDR_W-1:0] addr_reg;
    logic              flash_macro_states_done;
    logic              buff_page_ready;
`ifdef FLASH_PROG_SEQ_VERIFY_EN
    logic              verify_pass;
    logic              verify_fail;
`endif

    modport master (
        output macro_states,
        output macro_states_valid,
        output addr_reg,
`ifdef FLASH_PROG_SEQ_VERIFY_EN
        input  verify_pass,
        input  verify_fail,
`endif
        input  flash_macro_states_done,
        input  buff_page_ready
    );

    modport slave (
        input  macro_states,
        input  macro_states_valid,
        input  addr_reg,
`ifdef FLASH_PROG_SEQ_VERIFY_EN
        output verify_pass,
        output verify_fail,
`endif
        output flash_macro_states_done,
        output buff_page_ready
    );
endinterface

// File: rtl/flash_prog_sequencer.sv
// rtl/flash_prog_sequencer.sv - erase-then-page-program sequencer for one flash programming job
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            one-cycle job start, taken only while busy=0
//   start_addr       job base address (sampled with start)
//   data_len         job length in bytes (sampled with start)
//   busy             job in progress
//   job_done         one-cycle pulse on successful completion
//   job_err          sticky error: 0 none, 1 misaligned, 2 timeout, 3 verify fail
//   mif (master)     command strobe/code/address out, done and buffer-ready in
// Optional macro FLASH_PROG_SEQ_VERIFY_EN adds a read-back (4'hD) after every page
// write, answered by verify_pass / verify_fail on mif.
module flash_prog_sequencer #(
    parameter int ADDR_W       = 32,
    parameter int LEN_W        = 32,
    parameter int PAGE_BYTES   = 256,
    parameter int SECTOR_BYTES = 4096,
    parameter int TIMEOUT_CYC  = 2**24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  data_len,
    output logic              busy,
    output logic              job_done,
    output logic [1:0]        job_err,
    flash_prog_sequencer_if.master mif
);
    localparam int CW     = LEN_W + 1;
    localparam int PG_SH  = $clog2(PAGE_BYTES);
    localparam int SEC_SH = $clog2(SECTOR_BYTES);
    localparam int TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]     TO_LAST  = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [ADDR_W-1:0] SEC_MASK = ADDR_W'(SECTOR_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_CALC, S_ERS_ISSUE, S_ERS_WAIT, S_PG_WAITBUF,
        S_PG_ISSUE, S_PG_WAIT, S_PG_ADV, S_DONE, S_ERR, S_VFY_ISSUE, S_VFY_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CW-1:0]     sec_total_q, sec_total_d, pg_total_q, pg_total_d;
    logic [CW-1:0]     sec_cnt_q, sec_cnt_d, pg_cnt_q, pg_cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [3:0]        code_q, code_d;
    logic              valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [CW-1:0]     sec_sum, pg_sum;
    logic              done_ok, timeout_hit;

    assign busy                   = busy_q;
    assign job_done               = done_q;
    assign job_err                = err_q;
    assign mif.macro_states       = code_q;
    assign mif.macro_states_valid = valid_q;
    assign mif.addr_reg           = addr_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        addr_d      = addr_q;
        len_d       = len_q;
        sec_total_d = sec_total_q;
        pg_total_d  = pg_total_q;
        sec_cnt_d   = sec_cnt_q;
        pg_cnt_d    = pg_cnt_q;
        timer_d     = '0;
        code_d      = code_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        // Ceiling division by power-of-two sizes; the extra bit absorbs the rounding carry.
        sec_sum     = {1'b0, len_q} + CW'(SECTOR_BYTES - 1);
        pg_sum      = {1'b0, len_q} + CW'(PAGE_BYTES - 1);
        // A completion coinciding with the strobe belongs to no command yet.
        done_ok     = mif.flash_macro_states_done && !valid_q;
        timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == TO_LAST);

        case (state_q)
            // DONE and ERR last one cycle with busy already low, so a start there is accepted.
            S_IDLE, S_DONE, S_ERR: begin
                state_d = S_IDLE;
                if (start) begin
                    base_d  = start_addr;
                    len_d   = data_len;
                    busy_d  = 1'b1;
                    err_d   = 2'd0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((base_q & SEC_MASK) != '0) begin
                    err_d   = 2'd1;
                    busy_d  = 1'b0;
                    state_d = S_ERR;
                end else if (len_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                sec_total_d = sec_sum >> SEC_SH;
                pg_total_d  = pg_sum >> PG_SH;
                sec_cnt_d   = '0;
                pg_cnt_d    = '0;
                addr_d      = base_q;
                state_d     = S_ERS_ISSUE;
            end
            S_ERS_ISSUE: begin
                code_d  = 4'hA;
                valid_d = 1'b1;
                state_d = S_ERS_WAIT;
            end
            S_ERS_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (done_ok) begin
                    sec_cnt_d = sec_cnt_q + CW'(1);
                    if (sec_cnt_q + CW'(1) == sec_total_q) begin
                        addr_d  = base_q;
                        state_d = S_PG_WAITBUF;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(SECTOR_BYTES);
                        state_d = S_ERS_ISSUE;
                    end
                end else if (timeout_hit) begin
                    err_d   = 2'd2;
                    busy_d  = 1'b0;
                    state_d = S_ERR;
                end
            end
            S_PG_WAITBUF: begin
                if (mif.buff_page_ready) state_d = S_PG_ISSUE;
            end
            S_PG_ISSUE: begin
                code_d  = 4'hC;
                valid_d = 1'b1;
                state_d = S_PG_WAIT;
            end
            S_PG_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (done_ok) begin
`ifdef FLASH_PROG_SEQ_VERIFY_EN
                    state_d = S_VFY_ISSUE;
`else
                    state_d = S_PG_ADV;
`endif
                end else if (timeout_hit) begin
                    err_d   = 2'd2;
                    busy_d  = 1'b0;
                    state_d = S_ERR;
                end
            end
`ifdef FLASH_PROG_SEQ_VERIFY_EN
            S_VFY_ISSUE: begin
                code_d  = 4'hD;
                valid_d = 1'b1;
                state_d = S_VFY_WAIT;
            end
            S_VFY_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (mif.verify_pass && !valid_q) begin
                    state_d = S_PG_ADV;
                end else if (mif.verify_fail && !valid_q) begin
                    err_d   = 2'd3;
                    busy_d  = 1'b0;
                    state_d = S_ERR;
                end else if (timeout_hit) begin
                    err_d   = 2'd2;
                    busy_d  = 1'b0;
                    state_d = S_ERR;
                end
            end
`endif
            S_PG_ADV: begin
                addr_d   = addr_q + ADDR_W'(PAGE_BYTES);
                pg_cnt_d = pg_cnt_q + CW'(1);
                if (pg_cnt_q + CW'(1) == pg_total_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_PG_WAITBUF;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            sec_total_q <= '0;
            pg_total_q  <= '0;
            sec_cnt_q   <= '0;
            pg_cnt_q    <= '0;
            timer_q     <= '0;
            code_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            sec_total_q <= sec_total_d;
            pg_total_q  <= pg_total_d;
            sec_cnt_q   <= sec_cnt_d;
            pg_cnt_q    <= pg_cnt_d;
            timer_q     <= timer_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_flash_prog_sequencer.sv
// tb/tb_flash_prog_sequencer.sv - directed self-checking bench for flash_prog_sequencer
module tb_flash_prog_sequencer;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_addr = '0;
    logic [31:0] data_len = '0;
    logic        busy, job_done;
    logic [1:0]  job_err;

    flash_prog_sequencer_if #(.ADDR_W(32)) mif ();

    flash_prog_sequencer #(
        .ADDR_W(32), .LEN_W(32), .PAGE_BYTES(256), .SECTOR_BYTES(4096), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .data_len(data_len),
        .busy(busy), .job_done(job_done), .job_err(job_err), .mif(mif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Strobe and completion log
    logic [3:0]  st_code[$];
    logic [31:0] st_addr[$];
    int          st_cyc[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n && mif.macro_states_valid) begin
            st_code.push_back(mif.macro_states);
            st_addr.push_back(mif.addr_reg);
            st_cyc.push_back(cyc);
        end
        if (rst_n && job_done) done_cnt++;
    end

    // Flash engine model: answers each strobe one cycle later
    bit         resp_en = 1'b1;
    int         vfy_cnt = 0;
    int         vfy_fail_idx = 0;
    logic [3:0] rcode;

    initial begin
        mif.flash_macro_states_done = 1'b0;
`ifdef FLASH_PROG_SEQ_VERIFY_EN
        mif.verify_pass = 1'b0;
        mif.verify_fail = 1'b0;
`endif
        forever begin
            @(posedge clk); #1;
            if (resp_en && rst_n && mif.macro_states_valid) begin
                rcode = mif.macro_states;
                @(posedge clk); #1;
`ifdef FLASH_PROG_SEQ_VERIFY_EN
                if (rcode == 4'hD) begin
                    vfy_cnt++;
                    if (vfy_cnt == vfy_fail_idx) mif.verify_fail = 1'b1;
                    else mif.verify_pass = 1'b1;
                end else
`endif
                mif.flash_macro_states_done = 1'b1;
                @(posedge clk); #1;
                mif.flash_macro_states_done = 1'b0;
`ifdef FLASH_PROG_SEQ_VERIFY_EN
                mif.verify_pass = 1'b0;
                mif.verify_fail = 1'b0;
`endif
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        st_code.delete();
        st_addr.delete();
        st_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] l);
        start_addr = a;
        data_len   = l;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (job_done !== 1'b0) begin n_bad++; $display("FAIL reset_job_done: got %b want 0", job_done); end
        n_cmp++; if (job_err !== 2'd0) begin n_bad++; $display("FAIL reset_job_err: got %0d want 0", job_err); end
        n_cmp++; if (mif.macro_states_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", mif.macro_states_valid); end
        n_cmp++; if (mif.macro_states !== 4'h0) begin n_bad++; $display("FAIL reset_code: got %h want 0", mif.macro_states); end
        n_cmp++; if (mif.addr_reg !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", mif.addr_reg); end
    endtask

    task automatic test_one_sector();
        int n;
        logic [3:0]  ec;
        logic [31:0] ea;
        clear_log();
        launch(32'h0001_0000, 32'd4096);
        wait_idle(n);
        n_cmp++; if (n >= 5000) begin n_bad++; $display("FAIL one_sector_hang: busy cycles %0d want <5000", n); end
        n_cmp++; if (st_code.size() !== 17) begin n_bad++; $display("FAIL one_sector_count: got %0d strobes want 17", st_code.size()); end
        for (int i = 0; i < 17 && i < st_code.size(); i++) begin
            ec = (i == 0) ? 4'hA : 4'hC;
            ea = (i == 0) ? 32'h0001_0000 : 32'h0001_0000 + 32'(i - 1) * 32'h100;
            n_cmp++;
            if (st_code[i] !== ec || st_addr[i] !== ea) begin
                n_bad++;
                $display("FAIL one_sector_strobe%0d: got %h@%h want %h@%h", i, st_code[i], st_addr[i], ec, ea);
            end
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL one_sector_done: got %0d pulses want 1", done_cnt); end
        n_cmp++; if (job_err !== 2'd0) begin n_bad++; $display("FAIL one_sector_err: got %0d want 0", job_err); end
    endtask

    task automatic test_partial_page();
        int n;
        logic [3:0]  ec;
        logic [31:0] ea;
        clear_log();
        launch(32'h0002_0000, 32'd4097);
        wait_idle(n);
        n_cmp++; if (st_code.size() !== 19) begin n_bad++; $display("FAIL partial_count: got %0d strobes want 19", st_code.size()); end
        for (int i = 0; i < 19 && i < st_code.size(); i++) begin
            ec = (i < 2) ? 4'hA : 4'hC;
            ea = (i < 2) ? 32'h0002_0000 + 32'(i) * 32'h1000 : 32'h0002_0000 + 32'(i - 2) * 32'h100;
            n_cmp++;
            if (st_code[i] !== ec || st_addr[i] !== ea) begin
                n_bad++;
                $display("FAIL partial_strobe%0d: got %h@%h want %h@%h", i, st_code[i], st_addr[i], ec, ea);
            end
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL partial_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_misaligned();
        int n;
        clear_log();
        launch(32'h0000_0100, 32'd4096);
        wait_idle(n);
        n_cmp++; if (n > 2) begin n_bad++; $display("FAIL misaligned_busy_drop: busy for %0d more cycles want <=2", n); end
        n_cmp++; if (st_code.size() !== 0) begin n_bad++; $display("FAIL misaligned_strobes: got %0d want 0", st_code.size()); end
        n_cmp++; if (job_err !== 2'd1) begin n_bad++; $display("FAIL misaligned_err: got %0d want 1", job_err); end
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL misaligned_done: got %0d pulses want 0", done_cnt); end
    endtask

    task automatic test_zero_len();
        int n;
        clear_log();
        launch(32'h0003_0000, 32'd0);
        wait_idle(n);
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL zero_len_done: got %0d pulses want 1", done_cnt); end
        n_cmp++; if (st_code.size() !== 0) begin n_bad++; $display("FAIL zero_len_strobes: got %0d want 0", st_code.size()); end
        n_cmp++; if (job_err !== 2'd0) begin n_bad++; $display("FAIL zero_len_err_cleared: got %0d want 0", job_err); end
    endtask

    task automatic test_buffer_wait();
        int n;
        int r;
        clear_log();
        mif.buff_page_ready = 1'b0;
        launch(32'h0004_0000, 32'd256);
        n = 0;
        while (st_code.size() < 1 && n < 200) begin @(posedge clk); #1; n++; end
        repeat (500) begin @(posedge clk); #1; end
        launch(32'h0000_1000, 32'd0);
        repeat (500) begin @(posedge clk); #1; end
        n_cmp++; if (st_code.size() !== 1) begin n_bad++; $display("FAIL bufwait_no_write: got %0d strobes want 1", st_code.size()); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bufwait_busy: got %b want 1", busy); end
        mif.buff_page_ready = 1'b1;
        r = cyc;
        n = 0;
        while (st_code.size() < 2 && n < 50) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (st_code.size() < 2) begin
            n_bad++; $display("FAIL bufwait_write_missing: got %0d strobes want 2", st_code.size());
        end else begin
            if (st_cyc[1] - r > 2) begin n_bad++; $display("FAIL bufwait_latency: got %0d cycles want <=2", st_cyc[1] - r); end
            n_cmp++;
            if (st_code[1] !== 4'hC || st_addr[1] !== 32'h0004_0000) begin
                n_bad++; $display("FAIL bufwait_write: got %h@%h want c@00040000", st_code[1], st_addr[1]);
            end
        end
        wait_idle(n);
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL bufwait_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_timeout();
        int n;
        int e;
        clear_log();
        resp_en = 1'b0;
        launch(32'h0005_0000, 32'd256);
        n = 0;
        while (job_err == 2'd0 && n < 500) begin @(posedge clk); #1; n++; end
        e = cyc;
        n_cmp++; if (job_err !== 2'd2) begin n_bad++; $display("FAIL timeout_err: got %0d want 2", job_err); end
        n_cmp++; if (st_code.size() !== 1) begin n_bad++; $display("FAIL timeout_strobes: got %0d want 1", st_code.size()); end
        else begin
            n_cmp++;
            if (e - st_cyc[0] !== TO) begin n_bad++; $display("FAIL timeout_latency: got %0d cycles want %0d", e - st_cyc[0], TO); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_busy: got %b want 0", busy); end
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL timeout_done: got %0d pulses want 0", done_cnt); end
        resp_en = 1'b1;
    endtask

    task automatic test_reset_mid_job();
        int n;
        clear_log();
        launch(32'h0006_0000, 32'd1024);
        n = 0;
        while (st_code.size() < 3 && n < 500) begin @(posedge clk); #1; n++; end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || job_done !== 1'b0 || job_err !== 2'd0 || mif.macro_states_valid !== 1'b0 ||
            mif.macro_states !== 4'h0 || mif.addr_reg !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mid: got busy=%b done=%b err=%0d valid=%b code=%h addr=%h want all 0",
                     busy, job_done, job_err, mif.macro_states_valid, mif.macro_states, mif.addr_reg);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_two_page();
        int n;
        logic [3:0]  ec[$];
        logic [31:0] ea[$];
        clear_log();
`ifdef FLASH_PROG_SEQ_VERIFY_EN
        vfy_cnt = 0;
        vfy_fail_idx = 2;
        ec = '{4'hA, 4'hC, 4'hD, 4'hC, 4'hD};
        ea = '{32'h0007_0000, 32'h0007_0000, 32'h0007_0000, 32'h0007_0100, 32'h0007_0100};
`else
        ec = '{4'hA, 4'hC, 4'hC};
        ea = '{32'h0007_0000, 32'h0007_0000, 32'h0007_0100};
`endif
        launch(32'h0007_0000, 32'd512);
        wait_idle(n);
        n_cmp++; if (st_code.size() !== ec.size()) begin n_bad++; $display("FAIL two_page_count: got %0d want %0d", st_code.size(), ec.size()); end
        for (int i = 0; i < ec.size() && i < st_code.size(); i++) begin
            n_cmp++;
            if (st_code[i] !== ec[i] || st_addr[i] !== ea[i]) begin
                n_bad++;
                $display("FAIL two_page_strobe%0d: got %h@%h want %h@%h", i, st_code[i], st_addr[i], ec[i], ea[i]);
            end
        end
`ifdef FLASH_PROG_SEQ_VERIFY_EN
        n_cmp++; if (job_err !== 2'd3) begin n_bad++; $display("FAIL verify_err: got %0d want 3", job_err); end
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL verify_done: got %0d pulses want 0", done_cnt); end
        vfy_fail_idx = 0;
`else
        n_cmp++; if (job_err !== 2'd0) begin n_bad++; $display("FAIL two_page_err: got %0d want 0", job_err); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL two_page_done: got %0d pulses want 1", done_cnt); end
`endif
    endtask

    initial begin
        mif.buff_page_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_one_sector();
        test_partial_page();
        test_misaligned();
        test_zero_len();
        test_buffer_wait();
        test_timeout();
        test_reset_mid_job();
        test_two_page();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/flash_prog_sequencer.md
Name: flash_prog_sequencer

Overview:
- Parametrised successor to the UART/flash macro sequencer; owns only the flash half of a programming job: erase, then page-program.
- Takes a validated start address and byte length from the UART menu layer.
- Issues macro commands (erase sector, write page, optional read-back) to the flash macro engine, pacing each page write against the UART receive buffer.
- Counts sectors and pages exactly (ceiling division), enforces alignment, times out stalled handshakes, and reports done or error.

Parameters:
- ADDR_W, 32, width of flash byte address.
- LEN_W, 32, width of job byte length.
- PAGE_BYTES, 256, program page size; power of two.
- SECTOR_BYTES, 4096, erase sector size; power of two, multiple of PAGE_BYTES.
- TIMEOUT_CYC, 2**24, maximum cycles waiting on any flash done; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle job start; ignored unless busy=0.
- start_addr  in  ADDR_W  job base address; sampled with start.
- data_len  in  LEN_W  job length in bytes; sampled with start.
- macro_states  out  4  command code: 4'hA erase sector, 4'hC write page, 4'hD read page.
- macro_states_valid  out  1  one-cycle command strobe.
- flash_macro_states_done  in  1  one-cycle completion from flash engine.
- buff_page_ready  in  1  at least PAGE_BYTES bytes are buffered for programming.
- addr_reg  out  ADDR_W  address of the current command.
- busy  out  1  job in progress.
- job_done  out  1  one-cycle pulse on successful completion.
- job_err  out  2  sticky error code, cleared on next accepted start: 0 none, 1 misaligned, 2 timeout, 3 verify fail.

Behaviour:
- Reset (async assert, sync release): state IDLE; every output 0; all counters 0.
- Counts, latched in CALC using internal LEN_W+1-bit sums:
  - sec_total = ceil(data_len/SECTOR_BYTES).
  - pg_total = ceil(data_len/PAGE_BYTES).
  - Shift/mask only, no dividers.
- IDLE: on start, latch inputs, set busy=1, clear job_err, go to CHECK.
- CHECK:
  - start_addr mod SECTOR_BYTES != 0 -> ERR, code 1.
  - Else data_len==0 -> DONE; no commands are issued.
  - Else -> CALC.
- CALC: compute counts; addr_reg=start_addr; -> ERS_ISSUE.
- ERS_ISSUE: macro_states=4'hA, valid=1 for exactly one cycle; -> ERS_WAIT.
- ERS_WAIT: on done:
  - addr_reg += SECTOR_BYTES, sec_cnt += 1.
  - sec_cnt==sec_total -> reload addr_reg=start_addr, -> PG_WAITBUF.
  - Else -> ERS_ISSUE.
- PG_WAITBUF: waits indefinitely, with no timeout, until buff_page_ready=1 -> PG_ISSUE.
- PG_ISSUE: macro_states=4'hC, one-cycle valid; -> PG_WAIT.
- PG_WAIT: on done -> PG_ADV (or VFY_ISSUE when verify is enabled).
- PG_ADV:
  - addr_reg += PAGE_BYTES, pg_cnt += 1.
  - pg_cnt==pg_total -> DONE.
  - Else -> PG_WAITBUF.
- DONE: job_done pulses one cycle; busy=0 the same cycle; -> IDLE.
- ERR: busy=0; job_err holds; -> IDLE.
- Timeout counter:
  - Cleared on every command strobe; runs only in *_WAIT states.
  - Reaching TIMEOUT_CYC -> ERR, code 2.
  - done arriving in the same cycle as the timeout wins (treated as success).
- done outside a *_WAIT state: ignored.
- done in the same cycle as the strobe: not accepted; the earliest acceptance is the cycle after valid.
- start while busy: ignored.
- addr_reg arithmetic wraps modulo 2**ADDR_W; no range check.
- The last partial page is still programmed as a full page; the buffer padding is supplied upstream.
- macro_states holds its last code between strobes.
- Command-to-command gap: ≥2 cycles.

Optional Feature:
- Macro: FLASH_PROG_SEQ_VERIFY_EN.
- Defined: adds inputs verify_pass and verify_fail (1 bit each, one-cycle pulses), and states VFY_ISSUE and VFY_WAIT.
  - After each page done -> VFY_ISSUE: macro_states=4'hD on the same addr_reg; -> VFY_WAIT.
  - verify_pass -> PG_ADV.
  - verify_fail -> ERR, code 3.
  - VFY_WAIT is timeout-checked.
- Undefined: neither port exists; PG_WAIT goes directly to PG_ADV; code 3 is never produced.

Test Plan:
- start_addr=0x0001_0000, data_len=4096 -> one 4'hA strobe at 0x10000, then 16 4'hC strobes at 0x10000..0x10F00 step 0x100, one job_done.
- start_addr=0x0002_0000, data_len=4097 -> two erases (0x20000, 0x21000), 17 page writes, last at 0x21000.
- start_addr=0x0000_0100 -> no strobes, job_err=1, busy drops within 2 cycles; data_len=0 at aligned addr -> job_done with zero strobes.
- Hold buff_page_ready=0 for 1000 cycles after the erase -> no 4'hC strobe; assert it -> strobe within 2 cycles.
- TIMEOUT_CYC=64, withhold done after the first erase -> job_err=2 exactly 64 cycles after the strobe; pull rst_n low mid-page -> all outputs 0 immediately.
- With FLASH_PROG_SEQ_VERIFY_EN, 2-page job, verify_fail on page 2 -> 4'hD strobe at page 2 address, job_err=3, no job_done.
